bsearch_engine: RTL and testbench

//  Parametrised binary-search engine over a sorted (ascending, unsigned) synchronous-read memory.

---
 rtl/bsearch_pkg.sv | 23 ++
 rtl/bsearch_lat_cnt.sv | 43 ++++
 rtl/bsearch_engine.sv | 174 +++++++++++++++++
 tb/tb_bsearch_engine.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/bsearch_pkg.sv
// ============================================================================
// bsearch_pkg : shared FSM state encoding and memory-latency limits.
// Rev 1.0
// ============================================================================
`default_nettype none

package bsearch_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ISSUE = 3'd1,
        ST_WAIT  = 3'd2,
        ST_CMP   = 3'd3,
        ST_DONE  = 3'd4
    } state_e;

    localparam int MEM_LAT_MIN = 1;
    localparam int MEM_LAT_MAX = 3;
    localparam int LAT_CW      = 2;

endpackage

`default_nettype wire

// File: rtl/bsearch_lat_cnt.sv
// ============================================================================
// bsearch_lat_cnt : loadable down-counter timing the memory read latency.
// Rev 1.0
// ============================================================================
`default_nettype none

module bsearch_lat_cnt
    import bsearch_pkg::*;
#(
    parameter int MEM_LAT = 1
) (
    input  logic clk,
    input  logic clr,
    input  logic load_i,
    input  logic dec_i,
    output logic zero_o
);

    logic [LAT_CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = LAT_CW'(MEM_LAT);
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - LAT_CW'(1);
        end
    end

    // Flags the cycle in which the count reaches zero, so WAIT lasts exactly MEM_LAT cycles.
    assign zero_o = (cnt_d == '0);

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

`default_nettype wire

// File: rtl/bsearch_engine.sv
// ============================================================================
// bsearch_engine : binary search over a sorted synchronous-read memory.
// Optional macro BSEARCH_LOWER_BOUND_EN returns the insertion point on a miss.
// Rev 1.0
// ============================================================================
`default_nettype none

module bsearch_engine
    import bsearch_pkg::*;
#(
    parameter int DW      = 8,
    parameter int AW      = 5,
    parameter int MEM_LAT = 1
) (
    input  logic          clk,
    input  logic          clr,
    input  logic          start,
    input  logic [DW-1:0] key,
    output logic          busy,
    output logic          done,
    output logic          found,
    output logic [AW:0]   L,
    output logic [AW:0]   probes,
    output logic [AW-1:0] Addr,
    output logic          mem_rd,
    input  logic [DW-1:0] Data
);

    localparam logic [AW:0] DEPTH = {1'b1, {AW{1'b0}}};
    localparam logic [AW:0] ONE   = {{AW{1'b0}}, 1'b1};

    if ((MEM_LAT < MEM_LAT_MIN) || (MEM_LAT > MEM_LAT_MAX)) begin : g_lat_range_err
        $error("bsearch_engine: MEM_LAT must be 1..3");
    end

    state_e        state_q, state_d;
    logic [DW-1:0] key_q, key_d;
    logic [AW:0]   lo_q, lo_d, hi_q, hi_d, mid_q, mid_d;
    logic [AW:0]   probes_q, probes_d, L_q, L_d;
    logic [AW-1:0] addr_q, addr_d;
    logic          rd_q, rd_d, found_q, found_d, busy_q, busy_d, done_q, done_d;
    logic [AW:0]   mid;
    logic          cnt_load, cnt_dec, cnt_zero;

    // floor((lo+hi)/2) built from halved operands, so no carry out of AW+1 bits.
    assign mid = {1'b0, lo_q[AW:1]} + {1'b0, hi_q[AW:1]} + {{AW{1'b0}}, lo_q[0] & hi_q[0]};

    bsearch_lat_cnt #(
        .MEM_LAT (MEM_LAT)
    ) u_lat_cnt (
        .clk    (clk),
        .clr    (clr),
        .load_i (cnt_load),
        .dec_i  (cnt_dec),
        .zero_o (cnt_zero)
    );

    always_comb begin
        state_d  = state_q;
        key_d    = key_q;
        lo_d     = lo_q;
        hi_d     = hi_q;
        mid_d    = mid_q;
        probes_d = probes_q;
        addr_d   = addr_q;
        rd_d     = 1'b0;
        found_d  = found_q;
        L_d      = L_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        cnt_load = 1'b0;
        cnt_dec  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                // A start coinciding with the done pulse is dropped.
                if (start && !done_q) begin
                    key_d    = key;
                    lo_d     = '0;
                    hi_d     = DEPTH;
                    probes_d = '0;
                    found_d  = 1'b0;
                    L_d      = '0;
                    busy_d   = 1'b1;
                    state_d  = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (lo_q == hi_q) begin
`ifdef BSEARCH_LOWER_BOUND_EN
                    L_d = lo_q;
`else
                    L_d = '0;
`endif
                    state_d = ST_DONE;
                end else begin
                    addr_d   = mid[AW-1:0];
                    mid_d    = mid;
                    rd_d     = 1'b1;
                    probes_d = probes_q + ONE;
                    cnt_load = 1'b1;
                    state_d  = ST_WAIT;
                end
            end
            ST_WAIT: begin
                cnt_dec = 1'b1;
                if (cnt_zero) begin
                    state_d = ST_CMP;
                end
            end
            ST_CMP: begin
                if (Data == key_q) begin
                    found_d = 1'b1;
                    L_d     = mid_q;
                    state_d = ST_DONE;
                end else if (Data < key_q) begin
                    lo_d    = mid_q + ONE;
                    state_d = ST_ISSUE;
                end else begin
                    hi_d    = mid_q;
                    state_d = ST_ISSUE;
                end
            end
            ST_DONE: begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_q  <= ST_IDLE;
            key_q    <= '0;
            lo_q     <= '0;
            hi_q     <= '0;
            mid_q    <= '0;
            probes_q <= '0;
            addr_q   <= '0;
            rd_q     <= 1'b0;
            found_q  <= 1'b0;
            L_q      <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            key_q    <= key_d;
            lo_q     <= lo_d;
            hi_q     <= hi_d;
            mid_q    <= mid_d;
            probes_q <= probes_d;
            addr_q   <= addr_d;
            rd_q     <= rd_d;
            found_q  <= found_d;
            L_q      <= L_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign found  = found_q;
    assign L      = L_q;
    assign probes = probes_q;
    assign Addr   = addr_q;
    assign mem_rd = rd_q;

endmodule

`default_nettype wire

// File: tb/tb_bsearch_engine.sv
// ============================================================================
// tb_bsearch_engine : table-driven and scoreboarded bench for bsearch_engine,
// memory holds mem[i] = 2*i+1. Rev 1.0
// ============================================================================
`default_nettype none

module tb_bsearch_engine;

    typedef struct {
        logic [7:0] key;
        logic       found;
        logic [5:0] L;
        logic [5:0] probes;   // 0 = not checked
        int         lat;      // 0 = not checked
        int         start_cyc;
    } exp_t;

`ifdef BSEARCH_LOWER_BOUND_EN
    localparam bit LB = 1'b1;
`else
    localparam bit LB = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       clr = 1'b1;
    logic       start = 1'b0, start3 = 1'b0;
    logic [7:0] key = 8'd0, key3 = 8'd0;
    logic       busy, done, found, mem_rd;
    logic [5:0] L, probes;
    logic [4:0] Addr;
    logic [7:0] Data;
    logic       busy3, done3, found3, mem_rd3;
    logic [5:0] L3, probes3;
    logic [4:0] Addr3;
    logic [7:0] Data3;

    logic [7:0] mem [32];
    logic [7:0] p1, p3_0, p3_1, p3_2;

    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];
    exp_t vecs[10];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        for (int i = 0; i < 32; i++) mem[i] = 8'(2 * i + 1);
    end

    // Synchronous-read memory models; read data is zero unless a read was issued.
    always @(posedge clk) begin
        p1   <= mem_rd ? mem[Addr] : 8'd0;
        p3_0 <= mem_rd3 ? mem[Addr3] : 8'd0;
        p3_1 <= p3_0;
        p3_2 <= p3_1;
    end
    assign Data  = p1;
    assign Data3 = p3_2;

    bsearch_engine #(.DW(8), .AW(5), .MEM_LAT(1)) u_dut (
        .clk(clk), .clr(clr), .start(start), .key(key), .busy(busy), .done(done),
        .found(found), .L(L), .probes(probes), .Addr(Addr), .mem_rd(mem_rd), .Data(Data)
    );

    bsearch_engine #(.DW(8), .AW(5), .MEM_LAT(3)) u_dut3 (
        .clk(clk), .clr(clr), .start(start3), .key(key3), .busy(busy3), .done(done3),
        .found(found3), .L(L3), .probes(probes3), .Addr(Addr3), .mem_rd(mem_rd3), .Data(Data3)
    );

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic exp_t mk(input logic [7:0] k, input logic f, input logic [5:0] l,
                                input logic [5:0] p, input int lat);
        exp_t e;
        e.key = k; e.found = f; e.L = l; e.probes = p; e.lat = lat; e.start_cyc = 0;
        return e;
    endfunction

    task automatic wait_done(input int budget);
        int   n;
        exp_t e;
        n = 0;
        while (sb.size() != 0 && n < budget) begin
            @(negedge clk);
            n++;
            if (done) begin
                e = sb.pop_front();
                start = 1'b0;
                chk($sformatf("found[key=%0d]", e.key), int'(found), int'(e.found));
                chk($sformatf("L[key=%0d]", e.key), int'(L), int'(e.L));
                chk($sformatf("busy_at_done[key=%0d]", e.key), int'(busy), 0);
                if (e.probes != 0)
                    chk($sformatf("probes[key=%0d]", e.key), int'(probes), int'(e.probes));
                if (e.lat != 0)
                    chk($sformatf("latency[key=%0d]", e.key), cyc - e.start_cyc, e.lat);
            end
        end
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL done_timeout: %0d results outstanding after %0d cycles", sb.size(), budget);
            sb.delete();
        end
    endtask

    task automatic launch(input exp_t e_in);
        exp_t e;
        e = e_in;
        @(negedge clk);
        start = 1'b1;
        key   = e.key;
        e.start_cyc = cyc + 1;
        sb.push_back(e);
        @(negedge clk);
        start = 1'b0;
        wait_done(200);
    endtask

    task automatic run_lat3(input logic [7:0] k, input logic [5:0] exp_l,
                            input logic [5:0] exp_p, input int exp_lat);
        int  s;
        int  n;
        @(negedge clk);
        start3 = 1'b1;
        key3   = k;
        s      = cyc + 1;
        @(negedge clk);
        start3 = 1'b0;
        n = 0;
        while (!done3 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk($sformatf("lat3_done_seen[key=%0d]", k), int'(done3), 1);
        chk($sformatf("lat3_found[key=%0d]", k), int'(found3), 1);
        chk($sformatf("lat3_L[key=%0d]", k), int'(L3), int'(exp_l));
        chk($sformatf("lat3_probes[key=%0d]", k), int'(probes3), int'(exp_p));
        chk($sformatf("lat3_latency[key=%0d]", k), cyc - s, exp_lat);
    endtask

    initial begin
        logic [7:0] rk;
        logic [5:0] rl;
        int         n;

        // Spec-derived vectors, MEM_LAT=1: latency = probes*3+1, +1 on a miss.
        vecs[0] = mk(8'd33,  1'b1, 6'd16, 6'd1, 4);
        vecs[1] = mk(8'd1,   1'b1, 6'd0,  6'd6, 19);
        vecs[2] = mk(8'd64,  1'b0, LB ? 6'd32 : 6'd0, 6'd5, 17);
        vecs[3] = mk(8'd4,   1'b0, LB ? 6'd2  : 6'd0, 6'd5, 17);
        vecs[4] = mk(8'd63,  1'b1, 6'd31, 6'd5, 16);
        vecs[5] = mk(8'd0,   1'b0, 6'd0,  6'd6, 20);
        vecs[6] = mk(8'd17,  1'b1, 6'd8,  6'd2, 7);
        vecs[7] = mk(8'd62,  1'b0, LB ? 6'd31 : 6'd0, 6'd5, 17);
        vecs[8] = mk(8'd255, 1'b0, LB ? 6'd32 : 6'd0, 6'd5, 17);
        vecs[9] = mk(8'd3,   1'b1, 6'd1,  6'd5, 16);

        // Reset state, held and after release.
        repeat (3) @(negedge clk);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_found", int'(found), 0);
        chk("rst_L", int'(L), 0);
        chk("rst_probes", int'(probes), 0);
        chk("rst_Addr", int'(Addr), 0);
        chk("rst_mem_rd", int'(mem_rd), 0);
        clr = 1'b0;
        @(negedge clk);
        chk("post_rst_busy", int'(busy), 0);

        for (int i = 0; i < 10; i++) launch(vecs[i]);

        // Random keys checked against the closed form of mem[i]=2i+1.
        for (int i = 0; i < 12; i++) begin
            rk = 8'($urandom_range(0, 255));
            if (rk[0] && rk <= 8'd63) begin
                rl = 6'((rk - 8'd1) >> 1);
                launch(mk(rk, 1'b1, rl, 6'd0, 0));
            end else begin
                rl = (rk > 8'd63) ? 6'd32 : 6'(rk >> 1);
                launch(mk(rk, 1'b0, LB ? rl : 6'd0, 6'd0, 0));
            end
        end

        // Asynchronous clear in the WAIT state of the third probe of key=1.
        @(negedge clk);
        start = 1'b1;
        key   = 8'd1;
        @(negedge clk);
        start = 1'b0;
        n = 0;
        while (n < 50) begin
            if (mem_rd && probes == 6'd3) break;
            @(negedge clk);
            n++;
        end
        chk("pre_clr_probes", int'(probes), 3);
        chk("pre_clr_busy", int'(busy), 1);
        #1 clr = 1'b1;
        #1;
        chk("clr_busy", int'(busy), 0);
        chk("clr_done", int'(done), 0);
        chk("clr_found", int'(found), 0);
        chk("clr_L", int'(L), 0);
        chk("clr_probes", int'(probes), 0);
        chk("clr_mem_rd", int'(mem_rd), 0);
        #1 clr = 1'b0;
        launch(mk(8'd63, 1'b1, 6'd31, 6'd5, 16));

        // start held high across the whole search and the done cycle, key changed mid-search.
        @(negedge clk);
        start = 1'b1;
        key   = 8'd33;
        begin
            exp_t e;
            e = mk(8'd33, 1'b1, 6'd16, 6'd1, 4);
            e.start_cyc = cyc + 1;
            sb.push_back(e);
        end
        @(negedge clk);
        key = 8'd1;
        n = 0;
        while (!done && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("hold_done_seen", int'(done), 1);
        chk("hold_found", int'(found), 1);
        chk("hold_L", int'(L), 16);
        chk("hold_latency", cyc - sb[0].start_cyc, 4);
        sb.delete();
        @(negedge clk);
        start = 1'b0;
        chk("start_with_done_ignored", int'(busy), 0);
        repeat (3) begin
            @(negedge clk);
            chk("no_second_search", int'(busy | done), 0);
        end

        // Three-cycle memory.
        run_lat3(8'd33, 6'd16, 6'd1, 6);
        run_lat3(8'd1,  6'd0,  6'd6, 31);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish, %0d errors so far", errors);
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire
